// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//   Instruction fetch stage that feeds decode. It owns the PC and issues in-order
//   word reads to instruction memory. Returned words are buffered together with
//   their PCs in a small FIFO and handed to decode over a valid/ready handshake.
//   A redirect (taken branch/jump) flushes the FIFO. Reads that are still
//   outstanding at that point have their responses dropped when they arrive.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   imem_req_valid/ready/addr       read request toward instruction memory
//   imem_rsp_valid/data             in-order read responses (latency >= 1)
//   redirect_valid/pc               single-cycle fetch redirect
//   id_valid/ready, id_inst, id_pc  FIFO head toward decode
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int PW = $clog2(DEPTH);
  // One extra bit so that inflight + count cannot overflow.
  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  typedef enum logic {BOOT, FETCH} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [31:0]   last_pc;

  // PC tags of outstanding reads, in request order.
  logic [31:0]   tag_pc [DEPTH];
  logic [PW-1:0] tag_wr;
  logic [PW-1:0] tag_rd;

  // Instruction FIFO toward decode.
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  logic          req_fire;
  logic          rsp_fire;
  logic          rsp_keep;
  logic          pop;
  logic [CW-1:0] inflight_next;

  logic          unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + PW'(1);
  endfunction

  // Inflight plus FIFO occupancy is the credit bound. Because every accepted
  // read already owns a FIFO slot, a response can never overflow the FIFO.
  assign imem_req_valid = (state == FETCH) && !redirect_valid &&
                          ((inflight + count) < DEPTH_C);
  assign imem_req_addr  = fetch_pc;

  assign req_fire = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is a protocol error, so it is ignored.
  assign rsp_fire = imem_rsp_valid && (inflight != '0);
  // Responses belonging to squashed reads, or arriving in a redirect cycle, are discarded.
  assign rsp_keep = rsp_fire && (drop == '0) && !redirect_valid;
  assign pop      = id_valid && id_ready;

  assign inflight_next = inflight + CW'(req_fire) - CW'(rsp_fire);

  assign id_valid = (count != '0);
  assign id_inst  = id_valid ? fifo_inst[head] : NOP_INST;
  assign id_pc    = id_valid ? fifo_pc[head]   : last_pc;

  // Main sequential block: FSM, PC, outstanding-read tracking and FIFO.
  // On a redirect, drop is set to the number of reads still outstanding after
  // this edge. Every one of those responses belongs to the old path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      last_pc  <= RESET_PC;
    end else begin
      state    <= FETCH;
      inflight <= inflight_next;

      if (req_fire) begin
        tag_pc[tag_wr] <= fetch_pc;
        tag_wr         <= next_idx(tag_wr);
      end
      if (rsp_fire) begin
        tag_rd <= next_idx(tag_rd);
      end
      if (pop) begin
        last_pc <= fifo_pc[head];
      end

      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        drop     <= inflight_next;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (rsp_fire && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
        if (rsp_keep) begin
          fifo_pc[tail]   <= tag_pc[tag_rd];
          fifo_inst[tail] <= imem_rsp_data;
          tail            <= next_idx(tail);
        end
        if (pop) begin
          head <= next_idx(head);
        end
        count <= count + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

  rsp_with_no_outstanding: assert property (
    @(posedge clk) disable iff (rst) imem_rsp_valid |-> (inflight != '0)
  );

endmodule
